// File: rtl/pixel_pkg.sv
// pixel_pkg: shared types for the pixel plotter framebuffer stage.
`default_nettype none

package pixel_pkg;

  localparam int H_RES_DEF  = 640;
  localparam int V_RES_DEF  = 480;
  localparam int ADDR_W_DEF = 19;

  typedef logic [9:0]            coord_x_t;
  typedef logic [8:0]            coord_y_t;
  typedef logic [ADDR_W_DEF-1:0] fb_addr_t;

  typedef struct packed {
    coord_x_t x;
    coord_y_t y;
    logic     value;
  } pixel_req_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } plot_state_e;

endpackage

`default_nettype wire

// File: rtl/pixel_req_fifo.sv
// pixel_req_fifo: synchronous FIFO of pixel write requests, wrap-bit pointers.
`default_nettype none

module pixel_req_fifo
  import pixel_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     CLOCK_50,
  input  logic                     HRESETn,
  input  logic                     push_i,
  input  pixel_req_t               data_i,
  input  logic                     pop_i,
  output pixel_req_t               data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);

  pixel_req_t  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge CLOCK_50 or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

  // Equal index with differing wrap bits means the writer has lapped the reader.
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;

endmodule

`default_nettype wire

// File: rtl/pixel_plotter.sv
// pixel_plotter: queues pixel writes into a 1bpp dual-port framebuffer,
// serves registered display reads and runs a whole-screen clear sequencer.
`default_nettype none

module pixel_plotter
  import pixel_pkg::*;
#(
  parameter int H_RES      = H_RES_DEF,
  parameter int V_RES      = V_RES_DEF,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = ADDR_W_DEF
) (
  input  logic                          CLOCK_50,
  input  logic                          HRESETn,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [9:0]                    req_x,
  input  logic [8:0]                    req_y,
  input  logic                          req_value,
  input  logic                          clear_req,
  input  logic                          clear_value,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          range_err,
  input  logic                          err_clr,
  input  logic [9:0]                    rd_x,
  input  logic [8:0]                    rd_y,
  output logic                          rd_pixel
);

  localparam int                FB_WORDS  = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES*V_RES-1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam coord_x_t          H_LIM     = coord_x_t'(H_RES);
  localparam coord_y_t          V_LIM     = coord_y_t'(V_RES);

  function automatic logic [ADDR_W-1:0] pix_addr(input coord_x_t x, input coord_y_t y);
    return ADDR_W'(y) * ADDR_W'(H_RES) + ADDR_W'(x);
  endfunction

  plot_state_e       state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              fill_q, fill_d;
  logic              ready_en_q;
  logic              range_err_q, range_err_d;
  logic              rd_pixel_q;

  pixel_req_t        fifo_in, fifo_head;
  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic              req_fire, req_in_range, rd_in_range;

  logic              fb_we;
  logic [ADDR_W-1:0] fb_waddr;
  logic              fb_wdata;
  logic              fb_mem [FB_WORDS];

  // req_ready stays low until the first edge after reset release.
  assign req_ready    = !fifo_full && ready_en_q;
  assign req_fire     = req_valid && req_ready;
  assign req_in_range = (req_x < H_LIM) && (req_y < V_LIM);
  assign fifo_push    = req_fire && req_in_range;

  assign fifo_in.x     = req_x;
  assign fifo_in.y     = req_y;
  assign fifo_in.value = req_value;

  pixel_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLOCK_50 (CLOCK_50),
    .HRESETn  (HRESETn),
    .push_i   (fifo_push),
    .data_i   (fifo_in),
    .pop_i    (fifo_pop),
    .data_o   (fifo_head),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .level_o  (fifo_level)
  );

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    fill_d     = fill_q;
    fifo_pop   = 1'b0;
    fb_we      = 1'b0;
    fb_waddr   = '0;
    fb_wdata   = 1'b0;
    case (state_q)
      CLEAR: begin
        fb_we    = 1'b1;
        fb_waddr = clr_addr_q;
        fb_wdata = fill_q;
        if (clr_addr_q == LAST_ADDR) begin
          state_d    = IDLE;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + ADDR_ONE;
        end
      end
      default: begin
        // A clear pre-empts draining; queued requests wait and land on top of it.
        if (clear_req) begin
          state_d    = CLEAR;
          fill_d     = clear_value;
          clr_addr_d = '0;
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          fb_we    = 1'b1;
          fb_waddr = pix_addr(fifo_head.x, fifo_head.y);
          fb_wdata = fifo_head.value;
        end
      end
    endcase
  end

  always_comb begin
    range_err_d = range_err_q;
    if (req_fire && !req_in_range) range_err_d = 1'b1;
    else if (err_clr)              range_err_d = 1'b0;
  end

  always_ff @(posedge CLOCK_50 or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= CLEAR;
      clr_addr_q  <= '0;
      fill_q      <= 1'b0;
      ready_en_q  <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      fill_q      <= fill_d;
      ready_en_q  <= 1'b1;
      range_err_q <= range_err_d;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (fb_we) fb_mem[fb_waddr] <= fb_wdata;
  end

  assign rd_in_range = (rd_x < H_LIM) && (rd_y < V_LIM);

  always_ff @(posedge CLOCK_50 or negedge HRESETn) begin
    if (!HRESETn) rd_pixel_q <= 1'b0;
    else          rd_pixel_q <= rd_in_range ? fb_mem[pix_addr(rd_x, rd_y)] : 1'b0;
  end

  assign rd_pixel  = rd_pixel_q;
  assign range_err = range_err_q;
  assign busy      = (state_q == CLEAR) || (fifo_level != '0);

endmodule

`default_nettype wire

// File: doc/pixel_plotter.md
Name: pixel_plotter

Overview:
- Framebuffer stage between the CPU subsystem's pixel-write requests and the VGA display controller.
- Buffers write requests (x, y, value) in a small FIFO and drains them into a 1-bit-per-pixel dual-port framebuffer.
- Serves registered pixel reads to the display controller from the second port.
- Provides a whole-screen clear sequencer, which also runs automatically after reset so display contents are deterministic.

Parameters:
- H_RES, 640, visible width in pixels; bench uses 16
- V_RES, 480, visible height in pixels; bench uses 8
- FIFO_DEPTH, 8, request FIFO entries; power of two, at least 2
- ADDR_W, 19, framebuffer address width; must satisfy 2**ADDR_W >= H_RES*V_RES

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge
- HRESETn  in  1  asynchronous, active-low reset
- req_valid  in  1  write request present
- req_ready  out  1  FIFO can accept a request
- req_x  in  10  request column
- req_y  in  9  request row
- req_value  in  1  pixel value to write
- clear_req  in  1  single-cycle pulse: start a screen clear
- clear_value  in  1  fill value for a commanded clear
- busy  out  1  clear running or FIFO non-empty
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- range_err  out  1  sticky: an out-of-range request was dropped
- err_clr  in  1  clears range_err
- rd_x  in  10  display read column
- rd_y  in  9  display read row
- rd_pixel  out  1  registered framebuffer read data

Behaviour:
- Reset (HRESETn low, asynchronous):
  - FIFO is emptied; fifo_level=0, req_ready=0, range_err=0, rd_pixel=0, busy=1.
  - FSM enters CLEAR with fill value 0 and clear address 0.
- Address mapping: addr = y*H_RES + x, computed at ADDR_W bits with no truncation.
- FIFO push:
  - Occurs when req_valid && req_ready.
  - req_ready = !full && HRESETn deasserted for at least one edge; it is a registered-safe combinational function of state.
  - A request is captured at the accepting edge.
- Range check at push:
  - If req_x >= H_RES or req_y >= V_RES, the request is accepted (the handshake completes) but not stored.
  - range_err is set on the following edge.
  - range_err holds until err_clr is sampled high. If err_clr and a new error coincide, the error wins.
- FSM states:
  - IDLE:
    - If clear_req is high, go to CLEAR with the latched clear_value and addr 0.
    - Otherwise, if the FIFO is non-empty, pop the head and write it to the framebuffer on the same edge.
  - CLEAR:
    - Writes the fill value to one address per cycle, from 0 to H_RES*V_RES-1.
    - After the last address, returns to IDLE.
    - FIFO draining is suspended, but pushes are still accepted until the FIFO is full.
    - clear_req received while in CLEAR is ignored; the clear does not restart.
- Write priority: clear > FIFO drain. At most one framebuffer write per cycle.
- Latency:
  - Request accepted at edge N on an empty FIFO in IDLE: written at edge N+1.
  - A read of that address presented before edge N+2 returns the new value at edge N+2.
- Simultaneous push and pop on a non-full FIFO: level unchanged, FIFO order preserved.
- clear_req and a non-empty FIFO in the same IDLE cycle: the clear wins. The FIFO contents survive and drain after the clear, so queued writes overwrite cleared pixels.
- Read port:
  - rd_pixel is registered with 1-cycle latency.
  - Returns 0 if rd_x >= H_RES or rd_y >= V_RES.
  - A read and write to the same address in the same cycle returns the old data.
- busy = (state==CLEAR) || (fifo_level != 0).
- Reset mid-clear or mid-drain: all pending requests are discarded and the auto-clear restarts from 0. Framebuffer contents are overwritten by the clear.

Decomposition:
- Shared package pixel_pkg contains:
  - localparams H_RES_DEF and V_RES_DEF
  - typedefs coord_x_t (10 bits), coord_y_t (9 bits), fb_addr_t (ADDR_W bits)
  - packed struct pixel_req_t {x, y, value}
  - enum plot_state_e {IDLE, CLEAR}
- Sub-module pixel_req_fifo:
  - Synchronous FIFO of pixel_req_t with push/pop/full/empty/level.
  - Pointers are ADDR width + 1 wrap bit; asynchronous reset.
- The framebuffer is an inferred simple dual-port RAM in the top module, with no reset on its contents.

Test Plan (bench parameters H_RES=16, V_RES=8, FIFO_DEPTH=4):
- Reset release:
  - Stimulus: after 1 cycle, read every address.
  - Required: busy=1 for exactly 128 cycles, then busy=0; every rd_pixel=0.
- Single write:
  - Stimulus: push (x=3, y=2, value=1) in IDLE, then read (3,2).
  - Required: the write lands at addr 35; the read returns 1 two edges after acceptance. Neighbours (2,2) and (4,2) return 0.
- FIFO full:
  - Stimulus: assert clear_req (value 1), then push 5 back-to-back requests.
  - Required: 4 accepted, fifo_level=4, req_ready=0 on the fifth until the clear ends. After the clear, all 4 writes drain in order over 4 cycles and fifo_level returns to 0.
- Range error:
  - Stimulus: push (x=16, y=0).
  - Required: handshake completes, fifo_level stays 0, range_err=1 next cycle, no write occurs. err_clr drops range_err to 0.
- Out-of-range read:
  - Stimulus: rd_x=20, rd_y=1.
  - Required: rd_pixel=0 next cycle.
- Reset mid-clear:
  - Stimulus: assert HRESETn low at clear address 60 with 2 requests queued.
  - Required: fifo_level=0 immediately; after release, the clear restarts at 0; queued writes never appear; all pixels read 0.
